// File: rtl/daq_pkg.sv
// Shared field layout and channel ids for the DAQ result stream.
// Stream word: {channel, overflow, zero-extended count}.
package daq_pkg;

   localparam int DAQ_DATA_W  = 32;
   localparam int DAQ_CH_BIT  = 31;
   localparam int DAQ_OVF_BIT = 30;
   localparam int DAQ_CNT_LSB = 0;
   localparam int DAQ_CNT_MSB = 29;
   localparam int DAQ_CNT_FW  = DAQ_CNT_MSB - DAQ_CNT_LSB + 1;

   typedef enum logic {
      DAQ_CH0 = 1'b0,
      DAQ_CH1 = 1'b1
   } daq_ch_e;

   function automatic logic [DAQ_DATA_W-1:0] daq_pack(
      input logic                  ch,
      input logic                  ovf,
      input logic [DAQ_CNT_FW-1:0] cnt
   );
      logic [DAQ_DATA_W-1:0] w;
      w                          = '0;
      w[DAQ_CH_BIT]              = ch;
      w[DAQ_OVF_BIT]             = ovf;
      w[DAQ_CNT_MSB:DAQ_CNT_LSB] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/daq_res_fifo.sv
// Per-channel synchronous FIFO with first-word-fall-through read.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module daq_res_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         wr_en,
   input  logic [W-1:0] din,
   output logic         full,
   input  logic         rd_en,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         one_left
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr_reg;
   logic [AW:0]  rd_ptr_reg;
   logic [AW:0]  level;
   logic         do_wr;
   logic         do_rd;

   assign level    = wr_ptr_reg - rd_ptr_reg;
   assign full     = (level == (AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign one_left = (level == (AW+1)'(1));

   assign do_rd = rd_en && !empty && !clr;
   assign do_wr = wr_en && !clr && (!full || do_rd);

   // Head word is read combinationally so the output stage can load it the
   // cycle after it was written.
   assign dout = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_rd) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/daq_result_arbiter.sv
// Buffers two encoder-count channels and round-robin merges them onto one
// AXI4-Stream master, packetised by PKT_LEN beats or by session end.
module daq_result_arbiter
   import daq_pkg::*;
#(
   parameter int CNT_W      = 30,
   parameter int FIFO_DEPTH = 8,
   parameter int PKT_LEN    = 16,
   parameter int DROP_W     = 16
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              i_clr,
   input  logic              i_arm,
   input  logic              i_rdy0,
   input  logic [CNT_W-1:0]  i_cnt0,
   input  logic              i_ovf0,
   input  logic              i_rdy1,
   input  logic [CNT_W-1:0]  i_cnt1,
   input  logic              i_ovf1,
   output logic              m00_axis_tvalid,
   output logic [31:0]       m00_axis_tdata,
   output logic [3:0]        m00_axis_tstrb,
   output logic              m00_axis_tlast,
   input  logic              m00_axis_tready,
   output logic [DROP_W-1:0] o_drop0,
   output logic [DROP_W-1:0] o_drop1,
   output logic              o_busy
);

   localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

   logic [1:0]       rdy_vec;
   logic [1:0]       ovf_vec;
   logic [CNT_W-1:0] cnt_arr [2];
   logic [1:0]       fifo_full;
   logic [1:0]       fifo_empty;
   logic [1:0]       fifo_one;
   logic [1:0]       fifo_rd;
   logic [1:0]       fifo_wr_ok;
   logic [1:0]       fifo_drop;
   logic [31:0]      fifo_dout [2];

   logic              tvalid_reg;
   logic [31:0]       tdata_reg;
   logic              tlast_reg;
   daq_ch_e           rr_reg;
   logic [BEAT_W-1:0] beat_cnt_reg;
   logic              stale_reg;

   daq_ch_e           sel;
   daq_ch_e           other;
   logic              slot_free;
   logic              load;
   logic              handshake;
   logic              flush_last;
   logic [BEAT_W-1:0] load_idx;

   assign rdy_vec    = {i_rdy1, i_rdy0};
   assign ovf_vec    = {i_ovf1, i_ovf0};
   assign cnt_arr[0] = i_cnt0;
   assign cnt_arr[1] = i_cnt1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         localparam daq_ch_e CH_ID = daq_ch_e'(gi);
         logic [31:0]       din;
         logic [DROP_W-1:0] drop_reg;

         assign din           = daq_pack(CH_ID, ovf_vec[gi], DAQ_CNT_FW'(cnt_arr[gi]));
         assign fifo_rd[gi]   = load && (sel == CH_ID);
         assign fifo_wr_ok[gi] = rdy_vec[gi] && !i_clr && (!fifo_full[gi] || fifo_rd[gi]);
         assign fifo_drop[gi] = rdy_vec[gi] && !i_clr && fifo_full[gi] && !fifo_rd[gi];

         daq_res_fifo #(
            .W     (32),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk      (aclk),
            .rst_n    (aresetn),
            .clr      (i_clr),
            .wr_en    (rdy_vec[gi]),
            .din      (din),
            .full     (fifo_full[gi]),
            .rd_en    (fifo_rd[gi]),
            .dout     (fifo_dout[gi]),
            .empty    (fifo_empty[gi]),
            .one_left (fifo_one[gi])
         );

         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               drop_reg <= '0;
            end else if (i_clr) begin
               drop_reg <= '0;
            end else if (fifo_drop[gi] && (drop_reg != '1)) begin
               drop_reg <= drop_reg + 1'b1;
            end
         end
      end
   endgenerate

   always_comb begin
      sel = DAQ_CH0;
      if (!fifo_empty[0] && !fifo_empty[1]) begin
         sel = rr_reg;
      end else if (!fifo_empty[1]) begin
         sel = DAQ_CH1;
      end
   end

   assign other     = (sel == DAQ_CH0) ? DAQ_CH1 : DAQ_CH0;
   assign slot_free = !tvalid_reg || m00_axis_tready;
   assign load      = slot_free && (fifo_empty != 2'b11) && !i_clr;
   assign handshake = tvalid_reg && m00_axis_tready;

   // Session end: nothing left anywhere once this word leaves, counting
   // results that land in the FIFOs on the same edge.
   assign flush_last = !i_arm && fifo_one[sel] && !fifo_wr_ok[sel]
                       && fifo_empty[other] && !fifo_wr_ok[other];

   // Position of the word being loaded; a beat left over from before a clear
   // does not count towards the new packet.
   assign load_idx = (handshake && !stale_reg)
                     ? (tlast_reg ? '0 : beat_cnt_reg + 1'b1)
                     : beat_cnt_reg;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tvalid_reg   <= 1'b0;
         tdata_reg    <= '0;
         tlast_reg    <= 1'b0;
         rr_reg       <= DAQ_CH0;
         beat_cnt_reg <= '0;
         stale_reg    <= 1'b0;
      end else begin
         if (load) begin
            tvalid_reg <= 1'b1;
            tdata_reg  <= fifo_dout[sel];
            tlast_reg  <= (load_idx == BEAT_LAST) || flush_last;
         end else if (handshake) begin
            tvalid_reg <= 1'b0;
         end

         if (i_clr) begin
            rr_reg       <= DAQ_CH0;
            beat_cnt_reg <= '0;
            stale_reg    <= tvalid_reg && !handshake;
         end else begin
            if (load && !fifo_empty[0] && !fifo_empty[1]) begin
               rr_reg <= other;
            end
            if (handshake) begin
               stale_reg <= 1'b0;
               if (!stale_reg) begin
                  beat_cnt_reg <= tlast_reg ? '0 : beat_cnt_reg + 1'b1;
               end
            end
         end
      end
   end

   assign m00_axis_tvalid = tvalid_reg;
   assign m00_axis_tdata  = tdata_reg;
   assign m00_axis_tstrb  = 4'hF;
   assign m00_axis_tlast  = tlast_reg;
   assign o_drop0         = g_ch[0].drop_reg;
   assign o_drop1         = g_ch[1].drop_reg;
   assign o_busy          = tvalid_reg || (fifo_empty != 2'b11);

endmodule

// File: tb/tb_daq_result_arbiter.sv
// Scoreboard bench for daq_result_arbiter: expected beats are queued when
// strobes are driven and compared as the stream accepts them.
module tb_daq_result_arbiter;

   localparam int CNT_W      = 30;
   localparam int FIFO_DEPTH = 8;
   localparam int PKT_LEN    = 16;
   localparam int DROP_W     = 16;

   logic              clk;
   logic              aresetn;
   logic              i_clr;
   logic              i_arm;
   logic              i_rdy0;
   logic [CNT_W-1:0]  i_cnt0;
   logic              i_ovf0;
   logic              i_rdy1;
   logic [CNT_W-1:0]  i_cnt1;
   logic              i_ovf1;
   logic              tvalid;
   logic [31:0]       tdata;
   logic [3:0]        tstrb;
   logic              tlast;
   logic              tready;
   logic [DROP_W-1:0] o_drop0;
   logic [DROP_W-1:0] o_drop1;
   logic              o_busy;

   daq_result_arbiter #(
      .CNT_W      (CNT_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .PKT_LEN    (PKT_LEN),
      .DROP_W     (DROP_W)
   ) dut (
      .aclk            (clk),
      .aresetn         (aresetn),
      .i_clr           (i_clr),
      .i_arm           (i_arm),
      .i_rdy0          (i_rdy0),
      .i_cnt0          (i_cnt0),
      .i_ovf0          (i_ovf0),
      .i_rdy1          (i_rdy1),
      .i_cnt1          (i_cnt1),
      .i_ovf1          (i_ovf1),
      .m00_axis_tvalid (tvalid),
      .m00_axis_tdata  (tdata),
      .m00_axis_tstrb  (tstrb),
      .m00_axis_tlast  (tlast),
      .m00_axis_tready (tready),
      .o_drop0         (o_drop0),
      .o_drop1         (o_drop1),
      .o_busy          (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      logic [29:0] cnt0;
      logic        ovf0;
      logic [29:0] cnt1;
      logic        ovf1;
      logic [31:0] exp0;
      logic        last0;
      logic [31:0] exp1;
      logic        last1;
   } vec_t;

   beat_t exp_q[$];
   vec_t  vtab[8];
   int    tests = 0;
   int    fails = 0;
   int    beat_no = 0;
   bit    mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] data, input logic last);
      beat_t b;
      b.data = data;
      b.last = last;
      exp_q.push_back(b);
   endtask

   task automatic strobe(input bit r0, input logic [29:0] c0, input bit o0,
                         input bit r1, input logic [29:0] c1, input bit o1);
      i_rdy0 = r0; i_cnt0 = c0; i_ovf0 = o0;
      i_rdy1 = r1; i_cnt1 = c1; i_ovf1 = o1;
      tick();
      i_rdy0 = 1'b0;
      i_rdy1 = 1'b0;
   endtask

   task automatic clear_pulse();
      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
   endtask

   task automatic wait_drain(input string name, input bit toggle);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || o_busy) && n < 300) begin
         if (toggle) tready = ~tready;
         tick();
         n++;
      end
      check({"drain_", name}, (exp_q.size() == 0 && !o_busy), 1);
      tready = 1'b1;
   endtask

   // Stream monitor: scoreboard compare on accept, hold check after a stall.
   initial begin
      logic        stall_prev;
      logic [31:0] held_data;
      logic        held_last;
      beat_t       e;
      stall_prev = 1'b0;
      held_data  = '0;
      held_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("hold_stable", {tvalid, tlast, tdata}, {1'b1, held_last, held_data});
            end
            if (tvalid && tready) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL unexpected_beat: got 0x%08h, expected no beat", tdata);
               end else begin
                  e = exp_q.pop_front();
                  $display("[TB] beat %0d data=0x%08h last=%0d", beat_no, tdata, tlast);
                  check("beat_data", tdata, e.data);
                  check("beat_last", tlast, e.last);
               end
               beat_no++;
            end
            stall_prev = tvalid && !tready;
            held_data  = tdata;
            held_last  = tlast;
         end
      end
   end

   initial begin
      aresetn = 1'b0;
      i_clr   = 1'b0;
      i_arm   = 1'b0;
      i_rdy0  = 1'b0; i_cnt0 = '0; i_ovf0 = 1'b0;
      i_rdy1  = 1'b0; i_cnt1 = '0; i_ovf1 = 1'b0;
      tready  = 1'b1;

      for (int i = 0; i < 8; i++) begin
         vtab[i].cnt0  = 30'h100 + 30'(i);
         vtab[i].ovf0  = (i % 2) == 1;
         vtab[i].cnt1  = 30'h200 + 30'(i);
         vtab[i].ovf1  = (i % 4) >= 2;
         vtab[i].exp0  = 32'h0000_0100 + 32'(i) + ((i % 2) == 1 ? 32'h4000_0000 : 32'h0);
         vtab[i].last0 = 1'b0;
         vtab[i].exp1  = 32'h8000_0200 + 32'(i) + ((i % 4) >= 2 ? 32'h4000_0000 : 32'h0);
         vtab[i].last1 = (i == 7);
      end

      repeat (3) tick();
      check("rst_tvalid", tvalid, 0);
      check("rst_busy", o_busy, 0);
      aresetn = 1'b1;
      tick();
      check("rst_tdata", tdata, 0);
      check("rst_tlast", tlast, 0);
      check("rst_tstrb", tstrb, 4'hF);
      check("rst_drops", {o_drop1, o_drop0}, 0);
      mon_en = 1'b1;

      // Single strobe, session idle: one beat with tlast, 2 cycles latency.
      push(32'h0000_0123, 1'b1);
      strobe(1, 30'h123, 0, 0, 0, 0);
      check("lat_edge_k", tvalid, 0);
      tick();
      check("lat_edge_k1", tvalid, 1);
      wait_drain("t1", 0);

      // Simultaneous strobes: ch0 first, ch1 carries overflow and flush tlast.
      push(32'h0000_0005, 1'b0);
      push(32'hC000_0007, 1'b1);
      strobe(1, 30'd5, 0, 1, 30'd7, 1);
      wait_drain("t2", 0);

      // Ch1 overrun under backpressure: 8 queued + 1 held, 10th dropped.
      clear_pulse();
      i_arm  = 1'b1;
      tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < 9) push(32'h8000_0030 + 32'(i), 1'b0);
         strobe(0, 0, 0, 1, 30'h30 + 30'(i), 0);
      end
      check("t3_drop1", o_drop1, 1);
      check("t3_drop0", o_drop0, 0);
      check("t3_busy", o_busy, 1);
      tready = 1'b1;
      wait_drain("t3", 0);

      // Table: 8 rows into both FIFOs, then drain as a 16-beat interleave.
      clear_pulse();
      tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push(vtab[i].exp0, vtab[i].last0);
         push(vtab[i].exp1, vtab[i].last1);
         strobe(1, vtab[i].cnt0, vtab[i].ovf0, 1, vtab[i].cnt1, vtab[i].ovf1);
      end
      check("t4_drops", {o_drop1, o_drop0}, 0);
      tready = 1'b1;
      wait_drain("t4", 0);

      // Session end after 5 results, then a full packet restarting at beat 0.
      clear_pulse();
      tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(32'h0000_0050 + 32'(i), i == 4);
         strobe(1, 30'h50 + 30'(i), 0, 0, 0, 0);
      end
      tick();
      i_arm = 1'b0;
      tick();
      tready = 1'b1;
      wait_drain("t5a", 0);
      i_arm = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push(32'h0000_0060 + 32'(i), i == 15);
         strobe(1, 30'h60 + 30'(i), 0, 0, 0, 0);
      end
      wait_drain("t5b", 0);

      // Clear while a beat is held: that beat still completes, queue is flushed.
      clear_pulse();
      tready = 1'b0;
      push(32'h0000_0070, 1'b0);
      for (int i = 0; i < 3; i++) strobe(1, 30'h70 + 30'(i), 0, 0, 0, 0);
      clear_pulse();
      check("t7_busy_held", o_busy, 1);
      tready = 1'b1;
      tick();
      check("t7_empty", o_busy, 0);
      wait_drain("t7", 0);

      // Toggling backpressure over an interleaved burst.
      clear_pulse();
      tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(32'h4000_0080 + 32'(i), 1'b0);
         push(32'h8000_0090 + 32'(i), 1'b0);
         strobe(1, 30'h80 + 30'(i), 1, 1, 30'h90 + 30'(i), 0);
      end
      wait_drain("t6", 1);

      // Async reset mid-burst.
      clear_pulse();
      mon_en = 1'b0;
      tready = 1'b0;
      for (int i = 0; i < 10; i++) strobe(1, 30'hA0 + 30'(i), 0, 0, 0, 0);
      check("t6_drop0", o_drop0, 1);
      for (int i = 0; i < 3; i++) begin
         tready = ~tready;
         tick();
      end
      check("t6_mid_tvalid", tvalid, 1);
      #2;
      aresetn = 1'b0;
      #1;
      check("t6_rst_tvalid", tvalid, 0);
      check("t6_rst_drop0", o_drop0, 0);
      check("t6_rst_busy", o_busy, 0);
      check("t6_rst_tlast", tlast, 0);
      exp_q.delete();
      tick();
      aresetn = 1'b1;
      tick();
      check("t6_post_busy", o_busy, 0);
      tready = 1'b1;
      mon_en = 1'b1;
      i_arm  = 1'b0;
      push(32'hC000_03FF, 1'b1);
      strobe(0, 0, 0, 1, 30'h3FF, 1);
      wait_drain("t6_post", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
